// File: rtl/ysyx_25040111_icache_pkg.sv
// Shared definitions for the instruction cache.
// Geometry defaults, derived widths and FSM state encoding.
package ysyx_25040111_icache_pkg;

    localparam int ICACHE_CACHE_LS = 4;
    localparam int ICACHE_BLOCK_LS = 3;
    localparam int ICACHE_IDX_W    = ICACHE_CACHE_LS;
    localparam int ICACHE_OFF_W    = ICACHE_BLOCK_LS - 2;
    localparam int ICACHE_TAG_W    = 32 - ICACHE_CACHE_LS - ICACHE_BLOCK_LS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_AR,
        S_REFILL_R,
        S_RESP
    } icache_state_t;

endpackage

// File: rtl/ysyx_25040111_icache_array.sv
// Tag/valid/data storage for the direct-mapped icache.
// Combinational read, per-beat data write, tag+valid write, flush-all.
module ysyx_25040111_icache_array
    import ysyx_25040111_icache_pkg::*;
#(
    parameter int CACHE_LS = ICACHE_CACHE_LS,
    parameter int BLOCK_LS = ICACHE_BLOCK_LS
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CACHE_LS-1:0]            i_rd_idx,
    input  logic [BLOCK_LS-3:0]            i_rd_off,
    input  logic [31-CACHE_LS-BLOCK_LS:0]  i_rd_tag,
    output logic                           o_hit,
    output logic [31:0]                    o_rd_data,
    input  logic                           i_wr_en,
    input  logic [BLOCK_LS-3:0]            i_wr_off,
    input  logic [31:0]                    i_wr_data,
    input  logic                           i_tv_en,
    input  logic                           i_flush
);

    localparam int NLINE = 1 << CACHE_LS;
    localparam int NWORD = 1 << (BLOCK_LS - 2);

    logic [31:0]                   r_data [NLINE*NWORD];
    logic [31-CACHE_LS-BLOCK_LS:0] r_tag  [NLINE];
    logic [NLINE-1:0]              r_valid;

    // Refill beats land in the line selected by the read index.
    always_ff @(posedge clock) begin
        if (i_wr_en)
            r_data[{i_rd_idx, i_wr_off}] <= i_wr_data;
    end

    // Tag is written with the final refill beat.
    always_ff @(posedge clock) begin
        if (i_tv_en)
            r_tag[i_rd_idx] <= i_rd_tag;
    end

    // Valid bits: flush overrides a same-cycle line install.
    always_ff @(posedge clock) begin
        if (!reset)
            r_valid <= '0;
        else if (i_flush)
            r_valid <= '0;
        else if (i_tv_en)
            r_valid[i_rd_idx] <= 1'b1;
    end

    assign o_hit     = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_data = r_data[{i_rd_idx, i_rd_off}];

endmodule

// File: rtl/ysyx_25040111_icache.sv
// Direct-mapped read-only instruction cache with burst refill,
// fence.i flush and hit/miss counters.
module ysyx_25040111_icache
    import ysyx_25040111_icache_pkg::*;
#(
    parameter int CACHE_LS = ICACHE_CACHE_LS,
    parameter int BLOCK_LS = ICACHE_BLOCK_LS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    input  logic        rsp_ready,
    input  logic        flush,
    output logic        mem_arvalid,
    output logic [31:0] mem_araddr,
    output logic [7:0]  mem_arlen,
    input  logic        mem_arready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rlast,
    output logic        mem_err,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int OFF_W = BLOCK_LS - 2;
    localparam int BEATS = 1 << OFF_W;

    icache_state_t r_state;
    logic [31:2]      r_addr;
    logic [OFF_W-1:0] r_beat;
    logic             r_pend;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_data;
    logic             r_arvalid;
    logic             r_err;
    logic [31:0]      r_hit_cnt;
    logic [31:0]      r_miss_cnt;

    logic [CACHE_LS-1:0]           w_idx;
    logic [OFF_W-1:0]              w_off;
    logic [31-CACHE_LS-BLOCK_LS:0] w_tag;
    logic                          w_hit;
    logic [31:0]                   w_rd_data;
    logic                          w_last;
    logic                          w_beat_we;
    logic                          w_fill_done;
    logic                          w_flush_all;
    logic                          w_unused;

    assign w_tag = r_addr[31:BLOCK_LS+CACHE_LS];
    assign w_idx = r_addr[BLOCK_LS+CACHE_LS-1:BLOCK_LS];
    assign w_off = r_addr[BLOCK_LS-1:2];
    assign w_unused = ^req_addr[1:0];

    assign w_last      = (r_beat == OFF_W'(BEATS - 1));
    assign w_beat_we   = (r_state == S_REFILL_R) && mem_rvalid;
    assign w_fill_done = w_beat_we && w_last;

    // A flush during refill is deferred until the line is installed.
    assign w_flush_all =
        (flush && (r_state == S_IDLE || r_state == S_LOOKUP
                   || r_state == S_RESP))
        || (w_fill_done && (r_pend || flush));

    ysyx_25040111_icache_array #(
        .CACHE_LS (CACHE_LS),
        .BLOCK_LS (BLOCK_LS)
    ) u_array (
        .clock     (clock),
        .reset     (reset),
        .i_rd_idx  (w_idx),
        .i_rd_off  (w_off),
        .i_rd_tag  (w_tag),
        .o_hit     (w_hit),
        .o_rd_data (w_rd_data),
        .i_wr_en   (w_beat_we),
        .i_wr_off  (r_beat),
        .i_wr_data (mem_rdata),
        .i_tv_en   (w_fill_done),
        .i_flush   (w_flush_all)
    );

    // Request/response FSM with counters and refill bookkeeping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_pend      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_arvalid   <= 1'b0;
            r_err       <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr[31:2];
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_rsp_data  <= w_rd_data;
                        r_rsp_valid <= 1'b1;
                        r_hit_cnt   <= r_hit_cnt + 32'd1;
                        r_state     <= S_RESP;
                    end else begin
                        r_arvalid  <= 1'b1;
                        r_miss_cnt <= r_miss_cnt + 32'd1;
                        r_state    <= S_REFILL_AR;
                    end
                end
                S_REFILL_AR: begin
                    if (flush)
                        r_pend <= 1'b1;
                    if (mem_arready) begin
                        r_arvalid <= 1'b0;
                        r_beat    <= '0;
                        r_state   <= S_REFILL_R;
                    end
                end
                S_REFILL_R: begin
                    if (flush)
                        r_pend <= 1'b1;
                    if (mem_rvalid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == w_off)
                            r_rsp_data <= mem_rdata;
                        if (mem_rlast != w_last)
                            r_err <= 1'b1;
                        if (w_last) begin
                            r_pend      <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE) && reset;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_valid ? r_rsp_data : 32'd0;
    assign mem_arvalid = r_arvalid;
    assign mem_araddr  = r_arvalid
                       ? {r_addr[31:BLOCK_LS], {BLOCK_LS{1'b0}}} : 32'd0;
    assign mem_arlen   = r_arvalid ? 8'(BEATS - 1) : 8'd0;
    assign mem_err     = r_err;
    assign hit_cnt     = r_hit_cnt;
    assign miss_cnt    = r_miss_cnt;

endmodule
